// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 column driver.
// State encoding, default pixel format and BCM plane bit extraction.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  localparam int unsigned RGB_RES_DEF = 9;
  localparam int unsigned BITS_PER_CH = RGB_RES_DEF / 3;
  localparam int unsigned B_OFF       = 0;
  localparam int unsigned G_OFF       = BITS_PER_CH;
  localparam int unsigned R_OFF       = 2 * BITS_PER_CH;
  localparam int unsigned PIX_MAX     = 64;

  // Pixel is packed {R,G,B}, each field bpc bits wide.
  function automatic logic [2:0] plane_bits(
    input logic [PIX_MAX-1:0] px,
    input logic [5:0]         bpc,
    input logic [5:0]         p
  );
    logic [5:0] r_i;
    logic [5:0] g_i;
    r_i = (bpc << 1) + p;
    g_i = bpc + p;
    return {px[r_i], px[g_i], px[p]};
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Down-counter setting how long one BCM plane stays lit.
// Loads BASE_TIME<<plane on start; done marks the final lit cycle.
module hub75_bcm_timer #(
  parameter int unsigned BASE_TIME = 64,
  parameter int unsigned PLANES    = 3,
  parameter int unsigned PW        = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] plane,
  output logic          done
);

  localparam int unsigned CW =
    $clog2((BASE_TIME << (PLANES - 1)) + 1);

  logic [CW-1:0] cnt;

  // load on start, then count down to zero and park
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(BASE_TIME) << plane;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/hub75_column_driver.sv
// HUB75 column-pair driver: snapshots two columns per address,
// shifts them out as BCM planes and lights them on scan line a.
module hub75_column_driver
  import hub75_pkg::*;
#(
  parameter int unsigned SCAN_RATE = 32,
  parameter int unsigned NUM_ROWS  = 64,
  parameter int unsigned RGB_RES   = RGB_RES_DEF,
  parameter int unsigned BASE_TIME = 64
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   enable_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns_in,
  output logic [$clog2(SCAN_RATE)-1:0]           column_index1,
  output logic [$clog2(SCAN_RATE):0]             column_index2,
  output logic [2:0]                             rgb1_out,
  output logic [2:0]                             rgb2_out,
  output logic                                   hub_clk,
  output logic                                   hub_lat,
  output logic                                   hub_oe_n,
  output logic [$clog2(SCAN_RATE)-1:0]           hub_addr,
  output logic                                   frame_done
);

  localparam int unsigned AW    = $clog2(SCAN_RATE);
  localparam int unsigned BPC   = RGB_RES / 3;
  localparam int unsigned PW    = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned PIX_W = $clog2(2 * NUM_ROWS);
  localparam int unsigned RW    = PIX_W - 1;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]    plane;
  logic [PW-1:0]    plane_nx;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] pix_nx;
  logic [AW-1:0]    a_nx;
  logic [AW:0]      col2_nx;
  logic             done_nx;
  logic             wrap;

  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] snap;

  logic [RW-1:0]      k;
  logic [RW-1:0]      y;
  logic [RGB_RES-1:0] px0;
  logic [RGB_RES-1:0] px1;
  logic               in_shift;
  logic [2:0]         rgb1_nx;
  logic [2:0]         rgb2_nx;
  logic               clk_nx;
  logic               lat_nx;
  logic               oe_nx;
  logic [AW-1:0]      addr_nx;

  logic bcm_done;
  logic last_plane;
  logic shift_end;

  assign last_plane = (plane == PW'(BPC - 1));
  assign shift_end  = (pix == PIX_W'(2 * NUM_ROWS - 1));

  hub75_bcm_timer #(
    .BASE_TIME (BASE_TIME),
    .PLANES    (BPC),
    .PW        (PW)
  ) u_bcm (
    .clk   (clk_in),
    .rst   (rst_in),
    .start (state == LATCH),
    .plane (plane),
    .done  (bcm_done)
  );

  // state, counters and registered panel outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      plane         <= '0;
      pix           <= '0;
      column_index1 <= '0;
      column_index2 <= (AW+1)'(SCAN_RATE);
      frame_done    <= 1'b0;
      rgb1_out      <= '0;
      rgb2_out      <= '0;
      hub_clk       <= 1'b0;
      hub_lat       <= 1'b0;
      hub_oe_n      <= 1'b1;
      hub_addr      <= '0;
    end else begin
      state         <= state_nx;
      plane         <= plane_nx;
      pix           <= pix_nx;
      column_index1 <= a_nx;
      column_index2 <= col2_nx;
      frame_done    <= done_nx;
      rgb1_out      <= rgb1_nx;
      rgb2_out      <= rgb2_nx;
      hub_clk       <= clk_nx;
      hub_lat       <= lat_nx;
      hub_oe_n      <= oe_nx;
      hub_addr      <= addr_nx;
    end
  end

  // pixel snapshot, only ever written in LOAD
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      snap <= '0;
    end else if (state == LOAD) begin
      snap <= columns_in;
    end
  end

  // next-state sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable_in) state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (shift_end) state_nx = LATCH;
      LATCH:   state_nx = DISPLAY;
      DISPLAY: begin
        if (bcm_done) begin
          if (!last_plane)    state_nx = SHIFT;
          else if (enable_in) state_nx = LOAD;
          else                state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // next values of counters and outputs, looked ahead one cycle
  always_comb begin
    pix_nx   = '0;
    plane_nx = plane;
    a_nx     = column_index1;
    col2_nx  = column_index2;
    done_nx  = 1'b0;
    wrap     = 1'b0;
    if (state == SHIFT) pix_nx = pix + PIX_W'(1);
    if (state == LOAD) plane_nx = '0;
    if (state == DISPLAY && bcm_done) begin
      if (!last_plane) begin
        plane_nx = plane + PW'(1);
      end else begin
        plane_nx = '0;
        wrap     = (column_index1 == AW'(SCAN_RATE - 1));
        a_nx     = wrap ? '0 : column_index1 + AW'(1);
        col2_nx  = {1'b0, a_nx} + (AW+1)'(SCAN_RATE);
        done_nx  = wrap;
      end
    end

    k   = pix_nx[PIX_W-1:1];
    y   = RW'(NUM_ROWS - 1) - k;
    px0 = (state == LOAD) ? columns_in[0][y] : snap[0][y];
    px1 = (state == LOAD) ? columns_in[1][y] : snap[1][y];

    in_shift = (state_nx == SHIFT);
    rgb1_nx  = '0;
    rgb2_nx  = '0;
    if (in_shift) begin
      rgb1_nx = plane_bits(PIX_MAX'(px0), 6'(BPC), 6'(plane_nx));
      rgb2_nx = plane_bits(PIX_MAX'(px1), 6'(BPC), 6'(plane_nx));
    end
    clk_nx  = in_shift & pix_nx[0];
    lat_nx  = (state_nx == LATCH);
    oe_nx   = (state_nx != DISPLAY);
    addr_nx = lat_nx ? column_index1 : hub_addr;
  end

endmodule

// File: tb/tb_hub75_column_driver.sv
// Directed bench for hub75_column_driver.
// Traces outputs per cycle and checks them against hand values.
module tb_hub75_column_driver;

  localparam int NMAX = 27000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [1:0][63:0][8:0] cols;
  logic [8:0] mdl [2][64];

  logic [4:0] ci1;
  logic [5:0] ci2;
  logic [2:0] r1;
  logic [2:0] r2;
  logic       hc;
  logic       hl;
  logic       hoe;
  logic [4:0] ha;
  logic       fd;

  always #5 clk = ~clk;

  hub75_column_driver dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .enable_in     (en),
    .columns_in    (cols),
    .column_index1 (ci1),
    .column_index2 (ci2),
    .rgb1_out      (r1),
    .rgb2_out      (r2),
    .hub_clk       (hc),
    .hub_lat       (hl),
    .hub_oe_n      (hoe),
    .hub_addr      (ha),
    .frame_done    (fd)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic [2:0] t_r1 [NMAX];
  logic [2:0] t_r2 [NMAX];
  logic       t_hc [NMAX];
  logic       t_lat[NMAX];
  logic       t_oe [NMAX];
  logic [4:0] t_ha [NMAX];
  logic [4:0] t_ci1[NMAX];
  logic [5:0] t_ci2[NMAX];
  logic       t_fd [NMAX];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_r1[i] = r1;   t_r2[i] = r2;  t_hc[i] = hc;
      t_lat[i] = hl;  t_oe[i] = hoe; t_ha[i] = ha;
      t_ci1[i] = ci1; t_ci2[i] = ci2; t_fd[i] = fd;
    end
  endtask

  int oe_runs[$];
  int lat_n, lat_long, bad_rgb, fd_n, fd_at;
  int idx_steps, idx_bad, addr_bad, first_rise, last_rise;
  int rises[4];
  logic [2:0] first1[3];
  logic [2:0] first2[3];

  task automatic analyze(input int n);
    int run, seg, latrun, y;
    logic [8:0] p0, p1;
    logic [2:0] e1, e2;
    run = 0; seg = 0; latrun = 0;
    oe_runs.delete();
    lat_n = 0; lat_long = 0; bad_rgb = 0; fd_n = 0; fd_at = -1;
    idx_steps = 0; idx_bad = 0; addr_bad = 0;
    first_rise = -1; last_rise = -1;
    for (int s = 0; s < 4; s++) rises[s] = 0;
    for (int s = 0; s < 3; s++) begin first1[s] = 'x; first2[s] = 'x; end
    for (int i = 0; i < n; i++) begin
      if (!t_oe[i]) run++;
      else if (run > 0) begin oe_runs.push_back(run); run = 0; end
      if (t_lat[i]) begin
        latrun++;
        if (t_ha[i] !== t_ci1[i]) addr_bad++;
      end else if (latrun > 0) begin
        lat_n++;
        if (latrun != 1) lat_long++;
        latrun = 0;
        seg++;
      end
      if (i > 0 && t_hc[i] && !t_hc[i-1]) begin
        if (first_rise < 0) first_rise = i;
        last_rise = i;
        if (seg < 3 && rises[seg] < 64) begin
          y  = 63 - rises[seg];
          p0 = mdl[0][y];
          p1 = mdl[1][y];
          e1 = {p0[6+seg], p0[3+seg], p0[seg]};
          e2 = {p1[6+seg], p1[3+seg], p1[seg]};
          if (rises[seg] == 0) begin
            first1[seg] = t_r1[i];
            first2[seg] = t_r2[i];
          end
          if (t_r1[i] !== e1 || t_r2[i] !== e2) bad_rgb++;
        end
        if (seg < 4) rises[seg]++;
      end
      if (t_fd[i]) begin
        fd_n++;
        if (fd_at < 0) fd_at = i;
      end
      if (i > 0 && t_ci1[i] !== t_ci1[i-1]) begin
        idx_steps++;
        if (t_ci1[i] !== 5'(t_ci1[i-1] + 5'd1)) idx_bad++;
      end
      if (({1'b0, t_ci1[i]} + 6'd32) !== t_ci2[i]) idx_bad++;
    end
    if (run > 0) oe_runs.push_back(run);
  endtask

  task automatic set_cols(input logic [8:0] v);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 64; r++) begin
        cols[c][r] = v;
        mdl[c][r]  = v;
      end
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_addr_planes(input string tag);
    chk({tag, "_oe_runs"}, oe_runs.size(), 3);
    if (oe_runs.size() == 3) begin
      chk({tag, "_oe0"}, oe_runs[0], 64);
      chk({tag, "_oe1"}, oe_runs[1], 128);
      chk({tag, "_oe2"}, oe_runs[2], 256);
    end
    chk({tag, "_lat_n"}, lat_n, 3);
    chk({tag, "_lat_len"}, lat_long, 0);
    chk({tag, "_rise0"}, rises[0], 64);
    chk({tag, "_rise1"}, rises[1], 64);
    chk({tag, "_rise2"}, rises[2], 64);
    chk({tag, "_rgb"}, bad_rgb, 0);
  endtask

  initial begin
    int seen;
    set_cols(9'h000);

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_oe", hoe, 1);
    chk("rst_lat", hl, 0);
    chk("rst_clk", hc, 0);
    chk("rst_rgb1", r1, 0);
    chk("rst_rgb2", r2, 0);
    chk("rst_ci1", ci1, 0);
    chk("rst_ci2", ci2, 32);
    chk("rst_fd", fd, 0);
    chk("rst_addr", ha, 0);
    rst = 1'b0;

    // all ones: full planes, BCM lit times
    do_reset();
    set_cols(9'h1FF);
    en = 1'b1;
    capture(850);
    analyze(850);
    check_addr_planes("ones");
    chk("ones_first_rise", first_rise, 2);
    chk("ones_rgb1_p2", first1[2], 3'b111);
    chk("ones_addr", addr_bad, 0);
    chk("ones_ci_835", t_ci1[835], 0);
    chk("ones_ci_836", t_ci1[836], 1);

    // single pixel, one bit per plane
    do_reset();
    set_cols(9'h000);
    cols[0][63] = 9'b100_010_001;
    mdl[0][63]  = 9'b100_010_001;
    en = 1'b1;
    capture(850);
    analyze(850);
    chk("px_p0", first1[0], 3'b001);
    chk("px_p1", first1[1], 3'b010);
    chk("px_p2", first1[2], 3'b100);
    chk("px_rgb2", first2[1], 3'b000);
    chk("px_rest", bad_rgb, 0);

    // input scrambled after LOAD must not leak into shift data
    do_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 64; r++) begin
        cols[c][r] = 9'($urandom);
        mdl[c][r]  = cols[c][r];
      end
    en = 1'b1;
    fork
      capture(850);
      begin
        @(posedge clk);
        @(posedge clk);
        repeat (840) begin
          @(negedge clk);
          for (int c = 0; c < 2; c++)
            for (int r = 0; r < 64; r++)
              cols[c][r] = 9'($urandom);
        end
      end
    join
    analyze(850);
    check_addr_planes("snap");

    // one full sweep
    do_reset();
    set_cols(9'h0AA);
    en = 1'b1;
    capture(26760);
    analyze(26760);
    chk("sw_fd_n", fd_n, 1);
    chk("sw_fd_at", fd_at, 26752);
    chk("sw_ci1_wrap", t_ci1[26752], 0);
    chk("sw_ci2_wrap", t_ci2[26752], 32);
    chk("sw_ci1_last", t_ci1[26751], 31);
    chk("sw_steps", idx_steps, 32);
    chk("sw_idx", idx_bad, 0);
    chk("sw_addr", addr_bad, 0);
    chk("sw_lat_n", lat_n, 96);
    chk("sw_oe_runs", oe_runs.size(), 96);

    // async reset while lit on address 1
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      @(negedge clk);
      if (hoe == 1'b0 && ci1 == 5'd1) seen = 1;
    end
    chk("ar_lit_seen", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_oe", hoe, 1);
    chk("ar_ci1", ci1, 0);
    chk("ar_ci2", ci2, 32);
    chk("ar_lat", hl, 0);
    @(negedge clk);
    rst = 1'b0;

    // enable dropped during plane 1 shift
    do_reset();
    set_cols(9'h1FF);
    en = 1'b1;
    fork
      capture(1000);
      begin
        repeat (250) @(negedge clk);
        en = 1'b0;
      end
    join
    analyze(1000);
    check_addr_planes("drop");
    chk("drop_last_rise", last_rise, 578);
    chk("drop_oe_idle", t_oe[836], 1);
    chk("drop_oe_end", t_oe[999], 1);
    chk("drop_ci_836", t_ci1[836], 1);
    chk("drop_ci_end", t_ci1[999], 1);

    // re-enable resumes with LOAD on the next address
    en = 1'b1;
    capture(300);
    analyze(300);
    chk("re_first_rise", first_rise, 2);
    chk("re_oe_runs", oe_runs.size(), 1);
    if (oe_runs.size() > 0) chk("re_oe0", oe_runs[0], 64);
    chk("re_addr", t_ha[129], 1);
    chk("re_lat", t_lat[129], 1);
    chk("re_idx", idx_steps, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
